// File: rtl/bubble_outbuf_nch.sv
// Bubble output buffer: N single-bit channel RAMs with 2/4-channel write interleave,
// read registers clocked on falling MCLK, and a write-progress counter.
module bubble_outbuf_nch #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned PAGE_W   = 10,
  parameter int unsigned WRCNT_W  = 16
) (
  input  logic                MCLK,
  input  logic                nRESET,
  input  logic [2:0]          ACCTYPE,
  input  logic [ADDR_W-1:0]   BOUTCYCLENUM,
  input  logic                nBOUTCLKEN,
  input  logic                nNOBUBBLE,
  input  logic                MODE4,
  input  logic                nOUTBUFWCLKEN,
  input  logic [ADDR_W+1:0]   OUTBUFWADDR,
  input  logic                OUTBUFWDATA,
  output logic [CHANNELS-1:0] DOUT,
  output logic [WRCNT_W-1:0]  WRCNT,
  input  logic                WRCNT_CLR
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam logic [2:0]  ACC_BOOT = 3'b110;
  localparam logic [2:0]  ACC_USER = 3'b111;

  logic [ADDR_W-1:0]   rd_addr_c;
  logic [ADDR_W-1:0]   wr_addr_c;
  logic [1:0]          wr_ch_c;
  logic                wr_en_c;
  logic                mode4_c;
  logic [CHANNELS-1:0] rd_word_c;

  // Read address; all-ones is the reserved empty line used when idle.
  always_comb begin
    rd_addr_c = '1;
    if (nNOBUBBLE) begin
      if (ACCTYPE == ACC_BOOT) begin
        rd_addr_c = BOUTCYCLENUM;
      end else if (ACCTYPE == ACC_USER) begin
        rd_addr_c[PAGE_W-1:0] = BOUTCYCLENUM[PAGE_W-1:0];
      end
    end
  end

  assign mode4_c = (CHANNELS == 4) ? MODE4 : 1'b0;

  // Write decode: channel index is the inverted low address bit(s).
  always_comb begin
    wr_en_c = !nOUTBUFWCLKEN && ACCTYPE[1];
    if (mode4_c) begin
      wr_addr_c = OUTBUFWADDR[ADDR_W+1:2];
      wr_ch_c   = ~OUTBUFWADDR[1:0];
    end else begin
      wr_addr_c = OUTBUFWADDR[ADDR_W:1];
      wr_ch_c   = {1'b0, ~OUTBUFWADDR[0]};
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic ram [DEPTH];

    // Writes are dropped while reset is held.
    always_ff @(negedge MCLK) begin
      if (nRESET && wr_en_c && (wr_ch_c == 2'(i))) begin
        ram[wr_addr_c] <= OUTBUFWDATA;
      end
    end

    assign rd_word_c[i] = ram[rd_addr_c];
  end

  // Pins carry the inverted stored bit; reset leaves the idle (all ones) line.
  always_ff @(negedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      DOUT <= '1;
    end else if (!nBOUTCLKEN) begin
      DOUT <= ~rd_word_c;
    end
  end

  always_ff @(negedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      WRCNT <= '0;
    end else if (WRCNT_CLR || !ACCTYPE[1]) begin
      WRCNT <= '0;
    end else if (wr_en_c && (WRCNT != '1)) begin
      WRCNT <= WRCNT + WRCNT_W'(1);
    end
  end

endmodule
